// File: rtl/ex_fp_addsub_unit_if.sv
// Request/result bundle between the EX-stage control and the FP add/sub unit.
// Master drives launch/operands/flush; slave returns status, stall and the packed result.
interface ex_fp_addsub_unit_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              op_sub;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [ADDR_W-1:0] dest_addr;
  logic              flush;
  logic              busy;
  logic              stall;
  logic              result_valid;
  logic [31:0]       result;
  logic [ADDR_W-1:0] result_addr;
  logic              flag_ovf;
  logic              flag_unf;
  logic              flag_inv;

  modport master (
    output start, op_sub, op_a, op_b, dest_addr, flush,
    input  busy, stall, result_valid, result, result_addr, flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  start, op_sub, op_a, op_b, dest_addr, flush,
    output busy, stall, result_valid, result, result_addr, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/ex_fp_addsub_unit.sv
// Four-cycle single-precision add/subtract (ALIGN, ADD, NORM, DONE), truncating,
// denormals flushed; stalls the pipeline while an operation is in flight.
module ex_fp_addsub_unit #(
  parameter int ADDR_W     = 6,
  parameter int GUARD_BITS = 3
) (
  input logic                clk,
  input logic                reset,
  ex_fp_addsub_unit_if.slave bus
);
  localparam int MW  = 24 + GUARD_BITS + 1;
  localparam int LZW = $clog2(MW);
  localparam logic [7:0] SH_LIMIT = 8'(24 + GUARD_BITS);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       r_op_a;
  logic [31:0]       r_op_b;
  logic              r_op_sub;
  logic [ADDR_W-1:0] r_dest;

  logic [MW-1:0] r_mant_a;
  logic [MW-1:0] r_mant_b;
  logic [MW-1:0] r_sum;
  logic [7:0]    r_exp;
  logic          r_sign;
  logic          r_eff_sub;
  logic          r_spec;
  logic          r_spec_inv;
  logic [31:0]   r_spec_res;

  logic [31:0]       r_result;
  logic [ADDR_W-1:0] r_result_addr;
  logic              r_ovf;
  logic              r_unf;
  logic              r_inv;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && !bus.flush) w_next = S_ALIGN;
      S_ALIGN: w_next = bus.flush ? S_IDLE : S_ADD;
      S_ADD:   w_next = bus.flush ? S_IDLE : S_NORM;
      S_NORM:  w_next = bus.flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- ALIGN: unpack, classify, swap, shift ----------------
  logic [7:0]    w_ea, w_eb, w_e_big, w_e_small, w_diff;
  logic [23:0]   w_ma, w_mb, w_m_big, w_m_small;
  logic          w_sa, w_sb_eff, w_swap, w_eff_sub;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_nan_case;
  logic [MW-1:0] w_ext_small;
  logic [MW-1:0] w_small_sh;
  logic [31:0]   w_spec_res;

  always_comb begin
    w_ea     = r_op_a[30:23];
    w_eb     = r_op_b[30:23];
    w_ma     = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_op_a[22:0]};
    w_mb     = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_op_b[22:0]};
    w_sa     = r_op_a[31];
    w_sb_eff = r_op_b[31] ^ r_op_sub;
    w_eff_sub = w_sa ^ w_sb_eff;
    w_a_nan  = (w_ea == 8'hFF) && (r_op_a[22:0] != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (r_op_b[22:0] != 23'd0);
    w_a_inf  = (w_ea == 8'hFF) && (r_op_a[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (r_op_b[22:0] == 23'd0);
    w_nan_case = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub);

    w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
    w_e_big   = w_swap ? w_eb : w_ea;
    w_e_small = w_swap ? w_ea : w_eb;
    w_m_big   = w_swap ? w_mb : w_ma;
    w_m_small = w_swap ? w_ma : w_mb;
    w_diff    = w_e_big - w_e_small;
    w_ext_small = {1'b0, w_m_small, {GUARD_BITS{1'b0}}};
    // Bits falling off the bottom are dropped outright; no sticky bit.
    w_small_sh  = (w_diff >= SH_LIMIT) ? '0 : (w_ext_small >> w_diff);

    if (w_nan_case)   w_spec_res = 32'h7FC00000;
    else if (w_a_inf) w_spec_res = {w_sa, 8'hFF, 23'd0};
    else              w_spec_res = {w_sb_eff, 8'hFF, 23'd0};
  end

  // ---------------- NORM: leading-zero count and packing ----------------
  logic [LZW-1:0] w_lzc;
  logic           w_found;
  logic [10:0]    w_exp_n;
  logic [22:0]    w_frac;
  logic           w_ovf, w_unf;
  logic [31:0]    w_res;
  logic [2:0]     w_flags;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < MW - 1; i++) begin
      if (!w_found && r_sum[MW-2-i]) begin
        w_lzc   = LZW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_sum[MW-1]) begin
      w_exp_n = 11'(r_exp) + 11'd1;
      w_frac  = r_sum[MW-2 -: 23];
    end else begin
      w_exp_n = 11'(r_exp) - 11'(w_lzc);
      w_frac  = 23'((r_sum << w_lzc) >> GUARD_BITS);
    end
    w_ovf = !w_exp_n[10] && (w_exp_n >= 11'd255);
    w_unf = w_exp_n[10] || (w_exp_n == 11'd0);

    w_res   = {r_sign, w_exp_n[7:0], w_frac};
    w_flags = 3'b000;
    if (r_spec) begin
      w_res   = r_spec_res;
      w_flags = {2'b00, r_spec_inv};
    end else if (r_sum == '0) begin
      w_res = 32'h00000000;
    end else if (w_ovf) begin
      w_res   = {r_sign, 8'hFF, 23'd0};
      w_flags = 3'b100;
    end else if (w_unf) begin
      w_res   = {r_sign, 31'd0};
      w_flags = 3'b010;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start && !bus.flush) begin
      r_op_a   <= bus.op_a;
      r_op_b   <= bus.op_b;
      r_op_sub <= bus.op_sub;
      r_dest   <= bus.dest_addr;
    end
    if (r_state == S_ALIGN) begin
      r_mant_a   <= {1'b0, w_m_big, {GUARD_BITS{1'b0}}};
      r_mant_b   <= w_small_sh;
      r_exp      <= w_e_big;
      r_sign     <= w_swap ? w_sb_eff : w_sa;
      r_eff_sub  <= w_eff_sub;
      r_spec     <= w_nan_case || w_a_inf || w_b_inf;
      r_spec_inv <= w_nan_case;
      r_spec_res <= w_spec_res;
    end
    if (r_state == S_ADD)
      r_sum <= r_eff_sub ? (r_mant_a - r_mant_b) : (r_mant_a + r_mant_b);
  end

  // Outputs load on the NORM->DONE edge so a flush in NORM leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result      <= '0;
      r_result_addr <= '0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_inv         <= 1'b0;
    end else if (r_state == S_NORM && !bus.flush) begin
      r_result      <= w_res;
      r_result_addr <= r_dest;
      {r_ovf, r_unf, r_inv} <= w_flags;
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.stall        = (r_state == S_IDLE && bus.start) || (r_state == S_ALIGN) ||
                            (r_state == S_ADD) || (r_state == S_NORM);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.result       = r_result;
  assign bus.result_addr  = r_result_addr;
  assign bus.flag_ovf     = r_ovf;
  assign bus.flag_unf     = r_unf;
  assign bus.flag_inv     = r_inv;
endmodule
